// File: rtl/gate_lab_pkg.sv
// Shared definitions for the basic-gate labs.
// Holds the checker state encoding and the truth-table constants that let
// each gate lab reuse gate_response_checker by passing one of them as
// TRUTH_TABLE. Bit k of a table is the expected output for input vector k.
package gate_lab_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] NAND3_TT = 8'h7F;
    localparam logic [7:0] AND3_TT  = 8'h80;
    localparam logic [7:0] OR3_TT   = 8'hFE;
    localparam logic [7:0] NOR3_TT  = 8'h01;
    localparam logic [7:0] XOR3_TT  = 8'h96;

endpackage

// File: rtl/gate_response_checker_sat_counter.sv
// Saturating up-counter used for the checker's mismatch count.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, forces count to zero
//   clr   - synchronous clear, forces count to zero
//   inc   - increment by one unless already all-ones
//   count - current count value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/gate_response_checker.sv
// Response checker for the basic-gate labs. Compares each strobed sample of
// a gate's input vector and observed output against a truth table, tracks
// which input combinations have been seen, counts mismatches (saturating)
// and records the first failing vector. Reports done/pass once every
// combination has been covered.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - single-cycle pulse, begins or restarts a run
//   sample_valid    - in_vec/out_obs are valid this cycle
//   in_vec          - gate input vector, in_vec[N_IN-1] is the first input
//   out_obs         - observed gate output
//   busy            - run in progress
//   done            - all combinations covered, held until start or rst
//   pass            - with done, 1 iff no mismatches were seen
//   err_count       - saturating mismatch count
//   coverage        - bit k set once vector k has been sampled
//   first_err_valid - a mismatch has been captured this run
//   first_err_vec   - in_vec of the first mismatch
//
// state | meaning
// IDLE  | waiting for start, samples ignored
// CHECK | run in progress, every valid sample checked and counted
// DONE  | all vectors covered, outputs frozen until start
module gate_response_checker
    import gate_lab_pkg::*;
#(
    parameter int                  N_IN        = 3,
    parameter logic [2**N_IN-1:0]  TRUTH_TABLE = NAND3_TT,
    parameter int                  ERR_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sample_valid,
    input  logic [N_IN-1:0]    in_vec,
    input  logic               out_obs,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [2**N_IN-1:0] coverage,
    output logic               first_err_valid,
    output logic [N_IN-1:0]    first_err_vec
);

    localparam int NV = 2**N_IN;

    state_t          state;
    logic            expected;
    logic            mismatch;
    logic            take_sample;
    logic [NV-1:0]   cov_next;

    assign expected    = TRUTH_TABLE[in_vec];
    // Case-inequality so an X/Z output in simulation is reported as a failure.
    assign mismatch    = (out_obs !== expected);
    // start always wins over a coincident sample.
    assign take_sample = (state == CHECK) && sample_valid && !start;
    assign cov_next    = coverage | (NV'(1) << in_vec);

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .inc   (take_sample && mismatch),
        .count (err_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            coverage        <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else if (start) begin
            state           <= CHECK;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            coverage        <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else if (take_sample) begin
            coverage <= cov_next;
            if (mismatch && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_vec   <= in_vec;
            end
            if (&cov_next) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                // The counter updates on this same edge, so fold in this sample.
                pass  <= (err_count == '0) && !mismatch;
            end
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
module tb_gate_response_checker;

    logic       clk = 1'b0;
    logic       rst, start, sample_valid, out_obs;
    logic [2:0] in_vec;
    logic       busy, done, pass, first_err_valid;
    logic [7:0] err_count, coverage;
    logic [2:0] first_err_vec;

    int checks   = 0;
    int failures = 0;

    // Expected output per input vector (3-input NAND).
    localparam logic [7:0] TT = 8'h7F;

    // Reference model: run mode, set of vectors seen, error tally.
    int       m_mode;      // 0 idle, 1 running, 2 finished
    bit [7:0] m_seen;
    int       m_errs;
    bit       m_fev;
    bit [2:0] m_fvec;

    always #5 clk = ~clk;

    gate_response_checker dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .sample_valid    (sample_valid),
        .in_vec          (in_vec),
        .out_obs         (out_obs),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .coverage        (coverage),
        .first_err_valid (first_err_valid),
        .first_err_vec   (first_err_vec)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic gate_out(input logic [2:0] v);
        return !(v[2] && v[1] && v[0]);
    endfunction

    task automatic model_edge(input logic r, s, v, input logic [2:0] vec, input logic o);
        logic e;
        if (r) begin
            m_mode = 0; m_seen = '0; m_errs = 0; m_fev = 0; m_fvec = '0;
        end else if (s) begin
            m_mode = 1; m_seen = '0; m_errs = 0; m_fev = 0; m_fvec = '0;
        end else if (m_mode == 1 && v) begin
            e = TT[vec];
            m_seen[vec] = 1'b1;
            if (o != e) begin
                if (m_errs < 255) m_errs++;
                if (!m_fev) begin
                    m_fev  = 1;
                    m_fvec = vec;
                end
            end
            if (m_seen == 8'hFF) m_mode = 2;
        end
    endtask

    task automatic compare_all();
        chk("busy",      32'(busy),            32'(m_mode == 1));
        chk("done",      32'(done),            32'(m_mode == 2));
        chk("pass",      32'(pass),            32'(m_mode == 2 && m_errs == 0));
        chk("err_count", 32'(err_count),       32'(m_errs));
        chk("coverage",  32'(coverage),        32'(m_seen));
        chk("fe_valid",  32'(first_err_valid), 32'(m_fev));
        chk("fe_vec",    32'(first_err_vec),   32'(m_fvec));
    endtask

    task automatic step(input logic r, s, v, input logic [2:0] vec, input logic o);
        rst = r; start = s; sample_valid = v; in_vec = vec; out_obs = o;
        @(posedge clk);
        model_edge(r, s, v, vec, o);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 3'($urandom), 1'($urandom));
    endtask

    task automatic good(input logic [2:0] vec);
        step(0, 0, 1, vec, gate_out(vec));
    endtask

    task automatic bad(input logic [2:0] vec);
        step(0, 0, 1, vec, !gate_out(vec));
    endtask

    task automatic do_start();
        step(0, 1, 0, 3'd0, 1'b0);
    endtask

    initial begin
        m_mode = 0; m_seen = '0; m_errs = 0; m_fev = 0; m_fvec = '0;
        rst = 1; start = 0; sample_valid = 0; in_vec = '0; out_obs = 0;

        // Reset
        step(1, 0, 0, 3'd0, 1'b0);
        step(1, 1, 1, 3'd5, 1'b1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cov",  32'(coverage), 0);
        // Samples ignored in IDLE
        good(3'd1);
        chk("idle_cov", 32'(coverage), 0);

        // 1: correct sweep, sample every 10th cycle
        do_start();
        for (int k = 0; k < 8; k++) begin
            idle(9);
            good(3'(k));
        end
        chk("t1_done", 32'(done), 1);
        chk("t1_pass", 32'(pass), 1);
        chk("t1_cov",  32'(coverage), 32'hFF);
        // frozen in DONE
        bad(3'd2);
        chk("t1_frozen_err", 32'(err_count), 0);

        // 2: errors at 010 and 111 (the final vector)
        do_start();
        for (int k = 0; k < 8; k++) begin
            if (k == 2 || k == 7) bad(3'(k));
            else                  good(3'(k));
        end
        chk("t2_err",   32'(err_count), 2);
        chk("t2_fvec",  32'(first_err_vec), 32'h2);
        chk("t2_fev",   32'(first_err_valid), 1);
        chk("t2_pass",  32'(pass), 0);
        chk("t2_done",  32'(done), 1);

        // 3: repeats, 111 withheld
        do_start();
        for (int k = 0; k < 7; k++) begin
            good(3'(k));
            good(3'(k));
        end
        chk("t3_cov",  32'(coverage), 32'h7F);
        chk("t3_busy", 32'(busy), 1);
        chk("t3_done", 32'(done), 0);
        good(3'd7);
        chk("t3_done2", 32'(done), 1);
        chk("t3_pass2", 32'(pass), 1);

        // 4: saturation
        do_start();
        for (int i = 0; i < 300; i++) bad(3'd0);
        chk("t4_sat",  32'(err_count), 32'hFF);
        chk("t4_done", 32'(done), 0);
        for (int k = 1; k < 8; k++) good(3'(k));
        chk("t4_done2", 32'(done), 1);
        chk("t4_pass2", 32'(pass), 0);

        // 5: rst mid-run
        do_start();
        good(3'd0); bad(3'd1); good(3'd2); good(3'd3);
        step(1, 0, 1, 3'd4, 1'b1);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_err",  32'(err_count), 0);
        good(3'd5);
        chk("t5_cov",  32'(coverage), 0);

        // 6: restart with coincident sample
        do_start();
        good(3'd0); good(3'd1); bad(3'd2); good(3'd3); good(3'd4);
        step(0, 1, 1, 3'd5, !gate_out(3'd5));
        chk("t6_err", 32'(err_count), 0);
        chk("t6_cov", 32'(coverage), 0);
        chk("t6_fev", 32'(first_err_valid), 0);
        for (int k = 0; k < 8; k++) good(3'(k));
        chk("t6_pass", 32'(pass), 1);

        // Randomized runs against the model
        for (int run = 0; run < 25; run++) begin
            do_start();
            for (int c = 0; c < 150 && m_mode == 1; c++) begin
                logic [2:0] v;
                logic       o;
                v = 3'($urandom);
                o = gate_out(v) ^ ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 199) == 0)      step(1, 0, 1'($urandom), v, o);
                else if ($urandom_range(0, 99) == 0)  step(0, 1, 1'($urandom), v, o);
                else                                  step(0, 0, 1'($urandom), v, o);
            end
            idle(3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
